// File: rtl/gmr_ksctrl.sv
// gmr_ksctrl: sequencing controller for a Massey-Rueppel keystream generator.
// It loads the seeds, discards a fixed warm-up, then packs keystream bits MSB-first
// into words. Each word is handed to the consumer over valid/ready. The generator
// is frozen while a word waits in HOLD.
`timescale 1ns/1ps
module gmr_ksctrl #(
  parameter int WORD_W = 8,
  parameter int WARMUP = 32,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [6:0]        i_seed_lfsrM,
  input  logic [12:0]       i_seed_lfsrL,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_gen_load,
  output logic              o_gen_en,
  output logic [6:0]        o_gen_seed_lfsrM,
  output logic [12:0]       o_gen_seed_lfsrL,
  input  logic              i_keystream,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam bit HAS_WARMUP = (WARMUP > 0);
  localparam logic [15:0] WARM_LAST = HAS_WARMUP ? 16'(WARMUP - 1) : 16'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WARMUP, ST_RUN, ST_HOLD} state_t;

  state_t              state_reg, state_next;
  logic [6:0]          seed_m_reg;
  logic [12:0]         seed_l_reg;
  logic [LEN_W-1:0]    words_left_reg;
  logic [15:0]         warm_cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [WORD_W-2:0]   shift_reg;   // the newest bit is appended outside, so W-1 bits suffice
  logic [WORD_W-1:0]   data_reg;
  logic                valid_reg;
  logic                done_reg;

  logic              abort_hit;
  logic              xfer;
  logic              word_end;
  logic              last_word;
  logic [WORD_W-1:0] word_next;

  assign abort_hit = i_abort && (state_reg != ST_IDLE);
  assign xfer      = (state_reg == ST_HOLD) && i_ready;
  assign word_end  = (state_reg == ST_RUN) && (bit_cnt_reg == LAST_BIT);
  assign last_word = (words_left_reg == LEN_W'(1));
  assign word_next = {shift_reg, i_keystream};

  assign o_gen_seed_lfsrM = seed_m_reg;
  assign o_gen_seed_lfsrL = seed_l_reg;
  assign o_data           = data_reg;
  assign o_valid          = valid_reg;
  assign o_done           = done_reg;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and state-decoded generator controls. Abort has priority over everything.
  always_comb begin
    state_next = state_reg;
    o_busy     = (state_reg != ST_IDLE);
    o_gen_load = (state_reg == ST_LOAD);
    o_gen_en   = (state_reg == ST_WARMUP) || (state_reg == ST_RUN);
    case (state_reg)
      ST_IDLE:   if (i_start && (i_len != '0)) state_next = ST_LOAD;
      ST_LOAD:   state_next = HAS_WARMUP ? ST_WARMUP : ST_RUN;
      ST_WARMUP: if (warm_cnt_reg == 16'd0) state_next = ST_RUN;
      ST_RUN:    if (word_end) state_next = ST_HOLD;
      ST_HOLD:   if (xfer) state_next = last_word ? ST_IDLE : ST_RUN;
      default:   state_next = ST_IDLE;
    endcase
    if (abort_hit) state_next = ST_IDLE;
  end

  // Datapath: capture on start, warm-up count, bit packing and handshake bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seed_m_reg     <= '0;
      seed_l_reg     <= '0;
      words_left_reg <= '0;
      warm_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              // An all-zero seed would lock the LFSR, so force the LSB on.
              seed_m_reg     <= (i_seed_lfsrM == 7'd0)  ? 7'd1  : i_seed_lfsrM;
              seed_l_reg     <= (i_seed_lfsrL == 13'd0) ? 13'd1 : i_seed_lfsrL;
              words_left_reg <= i_len;
            end
          end
        end
        ST_LOAD: begin
          warm_cnt_reg <= WARM_LAST;
          bit_cnt_reg  <= '0;
        end
        ST_WARMUP: begin
          if (warm_cnt_reg != 16'd0) warm_cnt_reg <= warm_cnt_reg - 16'd1;
        end
        ST_RUN: begin
          shift_reg <= word_next[WORD_W-2:0];
          if (word_end) begin
            data_reg    <= word_next;
            valid_reg   <= 1'b1;
            bit_cnt_reg <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            valid_reg      <= 1'b0;
            words_left_reg <= words_left_reg - LEN_W'(1);
            if (last_word && !i_abort) done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
      // An abort drops any pending or just-completed word.
      if (abort_hit) valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gmr_ksctrl.sv
// Directed bench for gmr_ksctrl. It includes a behavioural generator (7/13-bit LFSRs
// with an AND/XOR combiner) driven by the controller's load/enable strobes.
`timescale 1ns/1ps
module tb_gmr_ksctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start0, abort, ready;
  logic [6:0]  seed_m;
  logic [12:0] seed_l;
  logic [15:0] len;

  logic        busy, done, gen_load, gen_en, ks, valid;
  logic [6:0]  gsm;
  logic [12:0] gsl;
  logic [7:0]  data;

  logic        busy0, done0, load0, en0, ks0, valid0;
  logic [6:0]  gsm0;
  logic [12:0] gsl0;
  logic [3:0]  data0;

  int total = 0;
  int bad   = 0;

  gmr_ksctrl #(.WORD_W(8), .WARMUP(32), .LEN_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_abort(abort),
    .i_seed_lfsrM(seed_m), .i_seed_lfsrL(seed_l), .i_len(len),
    .o_busy(busy), .o_done(done), .o_gen_load(gen_load), .o_gen_en(gen_en),
    .o_gen_seed_lfsrM(gsm), .o_gen_seed_lfsrL(gsl), .i_keystream(ks),
    .o_data(data), .o_valid(valid), .i_ready(ready)
  );

  gmr_ksctrl #(.WORD_W(4), .WARMUP(0), .LEN_W(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start0), .i_abort(abort),
    .i_seed_lfsrM(seed_m), .i_seed_lfsrL(seed_l), .i_len(len),
    .o_busy(busy0), .o_done(done0), .o_gen_load(load0), .o_gen_en(en0),
    .o_gen_seed_lfsrM(gsm0), .o_gen_seed_lfsrL(gsl0), .i_keystream(ks0),
    .o_data(data0), .o_valid(valid0), .i_ready(ready)
  );

  function automatic logic [6:0] step_m(input logic [6:0] m);
    return {m[5:0], m[6] ^ m[5]};
  endfunction
  function automatic logic [12:0] step_l(input logic [12:0] l);
    return {l[11:0], l[12] ^ l[3] ^ l[2] ^ l[0]};
  endfunction
  function automatic logic ks_fn(input logic [6:0] m, input logic [12:0] l);
    return (m[0] & l[0]) ^ m[6] ^ l[12];
  endfunction

  // Golden keystream: skip `skip` steps after load, then collect w bits MSB-first.
  function automatic logic [31:0] model_word(input logic [6:0] sm, input logic [12:0] sl,
                                             input int skip, input int w);
    logic [6:0]  m;
    logic [12:0] l;
    logic [31:0] r;
    m = sm; l = sl; r = '0;
    for (int i = 0; i < skip; i++) begin m = step_m(m); l = step_l(l); end
    for (int i = 0; i < w; i++) begin
      r = {r[30:0], ks_fn(m, l)};
      m = step_m(m); l = step_l(l);
    end
    return r;
  endfunction

  // Behavioural generators, one per controller instance.
  logic [6:0]  gm = '0, gm0 = '0;
  logic [12:0] gl = '0, gl0 = '0;
  always @(posedge clk) begin
    if (gen_load) begin gm <= gsm; gl <= gsl; end
    else if (gen_en) begin gm <= step_m(gm); gl <= step_l(gl); end
  end
  always @(posedge clk) begin
    if (load0) begin gm0 <= gsm0; gl0 <= gsl0; end
    else if (en0) begin gm0 <= step_m(gm0); gl0 <= step_l(gl0); end
  end
  assign ks  = ks_fn(gm, gl);
  assign ks0 = ks_fn(gm0, gl0);

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!valid && cyc < max) begin tick(); cyc++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; start0 = 0; abort = 0; ready = 0;
    seed_m = '0; seed_l = '0; len = '0;
    tick(); tick();
    total++;
    if ({busy, done, gen_load, gen_en, valid, data, gsm, gsl} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {busy, done, gen_load, gen_en, valid, data, gsm, gsl});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({busy, done, gen_load, gen_en, valid} !== 5'b0) begin
        bad++; $display("FAIL idle_quiet cyc=%0d got=%b want=00000", i, {busy, done, gen_load, gen_en, valid});
      end
    end
  endtask

  task automatic test_basic;
    int n_en, n_run, cyc;
    logic [31:0] e;
    seed_m = 7'h5A; seed_l = 13'h1ABC; len = 16'd2; ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if ({gen_load, gen_en, busy} !== 3'b101) begin
      bad++; $display("FAIL load_cycle got=%b want=101", {gen_load, gen_en, busy});
    end
    total++;
    if (gsm !== 7'h5A || gsl !== 13'h1ABC) begin
      bad++; $display("FAIL seed_out got=%h/%h want=5a/1abc", gsm, gsl);
    end
    n_en = 0;
    for (int i = 0; i < 32; i++) begin tick(); if (gen_en && !gen_load && !valid) n_en++; end
    total++;
    if (n_en != 32) begin bad++; $display("FAIL warmup_len got=%0d want=32", n_en); end
    n_run = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (gen_en && !valid) n_run++; end
    total++;
    if (n_run != 8) begin bad++; $display("FAIL run_len got=%0d want=8", n_run); end
    tick();
    e = model_word(7'h5A, 13'h1ABC, 32, 8);
    $display("basic word0 data=%h valid=%b", data, valid);
    total++;
    if (!valid || gen_en || data !== e[7:0]) begin
      bad++; $display("FAIL basic_word0 got=v%b en%b %h want=v1 en0 %h", valid, gen_en, data, e[7:0]);
    end
    cyc = 0;
    do begin tick(); cyc++; end while (!valid && cyc < 30);
    e = model_word(7'h5A, 13'h1ABC, 40, 8);
    $display("basic word1 data=%h after=%0d", data, cyc);
    total++;
    if (cyc != 9) begin bad++; $display("FAIL throughput got=%0d want=9", cyc); end
    total++;
    if (data !== e[7:0]) begin bad++; $display("FAIL basic_word1 got=%h want=%h", data, e[7:0]); end
    tick();
    total++;
    if ({done, busy, valid} !== 3'b100) begin
      bad++; $display("FAIL basic_done got=%b want=100", {done, busy, valid});
    end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", done); end
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [31:0] e;
    seed_m = 7'h33; seed_l = 13'h0F0F; len = 16'd2; ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(100, cyc);
    total++;
    if (!valid) begin bad++; $display("FAIL bp_timeout got=0 want=valid"); end
    e = model_word(7'h33, 13'h0F0F, 32, 8);
    $display("bp word0 data=%h", data);
    total++;
    if (data !== e[7:0]) begin bad++; $display("FAIL bp_word0 got=%h want=%h", data, e[7:0]); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (!valid || gen_en || data !== e[7:0]) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=v%b en%b %h want=v1 en0 %h", i, valid, gen_en, data, e[7:0]);
      end
    end
    ready = 1'b1; tick();
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", valid); end
    wait_valid(30, cyc);
    e = model_word(7'h33, 13'h0F0F, 40, 8);
    $display("bp word1 data=%h", data);
    total++;
    if (!valid || data !== e[7:0]) begin bad++; $display("FAIL bp_word1 got=v%b %h want=v1 %h", valid, data, e[7:0]); end
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done); end
  endtask

  task automatic test_zero_seed;
    int cyc;
    logic [31:0] e;
    seed_m = '0; seed_l = '0; len = 16'd1; ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (gsm !== 7'h01 || gsl !== 13'h0001) begin
      bad++; $display("FAIL zero_seed_sub got=%h/%h want=01/0001", gsm, gsl);
    end
    wait_valid(100, cyc);
    e = model_word(7'h01, 13'h0001, 32, 8);
    $display("zero-seed word data=%h", data);
    total++;
    if (!valid || data !== e[7:0]) begin bad++; $display("FAIL zero_seed_word got=v%b %h want=v1 %h", valid, data, e[7:0]); end
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL zero_seed_done got=%b want=1", done); end
  endtask

  task automatic test_abort;
    int cyc, seen;
    logic [31:0] e;
    seed_m = 7'h5A; seed_l = 13'h1ABC; len = 16'd2; ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 36; i++) begin tick(); if (valid) seen++; end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if ({busy, gen_en, valid, done} !== 4'b0) begin
      bad++; $display("FAIL abort_idle got=%b want=0000", {busy, gen_en, valid, done});
    end
    for (int i = 0; i < 12; i++) begin tick(); if (valid || done) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", seen); end
    seed_m = 7'h11; seed_l = 13'h0222; len = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(100, cyc);
    e = model_word(7'h11, 13'h0222, 32, 8);
    $display("after-abort word data=%h", data);
    total++;
    if (!valid || data !== e[7:0]) begin bad++; $display("FAIL abort_restart got=v%b %h want=v1 %h", valid, data, e[7:0]); end
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL abort_restart_done got=%b want=1", done); end
  endtask

  task automatic test_len_zero;
    len = 16'd0; start = 1'b1; tick(); start = 1'b0;
    total++;
    if ({done, gen_load, busy} !== 3'b100) begin
      bad++; $display("FAIL len0_done got=%b want=100", {done, gen_load, busy});
    end
    tick();
    total++;
    if ({done, gen_load, busy} !== 3'b000) begin
      bad++; $display("FAIL len0_after got=%b want=000", {done, gen_load, busy});
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    logic [31:0] e;
    seed_m = 7'h2C; seed_l = 13'h1234; len = 16'd1; ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 34; i++) tick();
    seed_m = 7'h7F; seed_l = 13'h1FFF; len = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (gsm !== 7'h2C || gsl !== 13'h1234) begin
      bad++; $display("FAIL busy_start_seed got=%h/%h want=2c/1234", gsm, gsl);
    end
    wait_valid(30, cyc);
    e = model_word(7'h2C, 13'h1234, 32, 8);
    $display("busy-start word data=%h", data);
    total++;
    if (!valid || data !== e[7:0]) begin bad++; $display("FAIL busy_start_word got=v%b %h want=v1 %h", valid, data, e[7:0]); end
    tick();
    total++;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL busy_start_done got=%b want=10", {done, busy}); end
  endtask

  task automatic test_warmup0;
    logic [31:0] e;
    seed_m = 7'h5A; seed_l = 13'h1ABC; len = 16'd1; ready = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    total++;
    if ({load0, en0} !== 2'b10) begin bad++; $display("FAIL w0_load got=%b want=10", {load0, en0}); end
    tick();
    total++;
    if ({load0, en0, valid0} !== 3'b010) begin bad++; $display("FAIL w0_run_next got=%b want=010", {load0, en0, valid0}); end
    for (int i = 0; i < 4; i++) tick();
    e = model_word(7'h5A, 13'h1ABC, 0, 4);
    $display("warmup0 word data=%h", data0);
    total++;
    if (!valid0 || data0 !== e[3:0]) begin bad++; $display("FAIL w0_word got=v%b %h want=v1 %h", valid0, data0, e[3:0]); end
    tick();
    total++;
    if (done0 !== 1'b1) begin bad++; $display("FAIL w0_done got=%b want=1", done0); end
  endtask

  task automatic test_async_reset;
    int cyc;
    seed_m = 7'h44; seed_l = 13'h0808; len = 16'd2; ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(100, cyc);
    total++;
    if (!valid) begin bad++; $display("FAIL ar_timeout got=0 want=valid"); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid, busy, gen_en} !== 3'b000) begin
      bad++; $display("FAIL async_reset got=%b want=000", {valid, busy, gen_en});
    end
    #10 rst_n = 1'b1;
    tick();
    total++;
    if ({valid, busy} !== 2'b00) begin bad++; $display("FAIL post_reset got=%b want=00", {valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_seed();
    test_abort();
    test_len_zero();
    test_start_ignored();
    test_warmup0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmr_ksctrl.md
Name: gmr_ksctrl

Overview:
Sequencing controller for the Massey-Rueppel keystream generator datapath (LFSR-M 7-bit, LFSR-L 13-bit, AND/XOR combiner). On a start command it loads the seeds into the generator and runs a fixed warm-up, discarding those bits. It then clock-enables the generator to collect keystream bits and packs them MSB-first into WORD_W-bit words. Words are delivered to a downstream consumer over a valid/ready handshake, and the generator stalls while a word is pending.

Parameters:
WORD_W, 8, keystream word width in bits (2..32).
WARMUP, 32, generator steps discarded after seed load (0..65535).
LEN_W, 16, width of the word-count request.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  reset, asynchronous, active-low.
i_start  in  1  single-cycle start request; sampled only in IDLE.
i_abort  in  1  synchronous abort of the current run.
i_seed_lfsrM  in  7  seed for LFSR-M, captured on accepted start.
i_seed_lfsrL  in  13  seed for LFSR-L, captured on accepted start.
i_len  in  LEN_W  number of words to produce, captured on accepted start.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle pulse when a run completes normally.
o_gen_load  out  1  generator seed-load strobe.
o_gen_en  out  1  generator step enable.
o_gen_seed_lfsrM  out  7  seed driven to the generator.
o_gen_seed_lfsrL  out  13  seed driven to the generator.
i_keystream  in  1  generator keystream bit for the current generator state.
o_data  out  WORD_W  packed keystream word.
o_valid  out  1  o_data is valid.
i_ready  in  1  consumer accepts o_data.

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE. All outputs, counters, the shift register and the captured seeds/length are 0.
- States: IDLE, LOAD, WARMUP, RUN, HOLD. All registered outputs are updated on the rising edge of i_clk.
- IDLE:
  - i_start=1 and i_len!=0: capture the seeds and i_len, then go to LOAD.
  - i_start=1 and i_len=0: no load; o_done pulses on the next cycle; remain in IDLE.
- Zero-seed protection: a captured seed that is all-zero is replaced by 1 (LSB set) before it is driven, because a zero seed locks the LFSR up. o_gen_seed_* hold the substituted captured values for the whole run.
- LOAD: exactly one cycle with o_gen_load=1 and o_gen_en=0. Next state is WARMUP if WARMUP>0, else RUN.
- WARMUP:
  - o_gen_en=1 for exactly WARMUP consecutive cycles; i_keystream is ignored.
  - A 16-bit down-counter loaded with WARMUP-1 sets the duration; the state exits to RUN when the counter reaches 0.
- RUN:
  - o_gen_en=1. Every cycle, i_keystream is shifted into the shift register from the LSB side, so the first bit ends up in the MSB.
  - At the edge that samples bit WORD_W: o_data receives the full word, o_valid goes to 1, and the state goes to HOLD.
  - A RUN segment is exactly WORD_W cycles.
- HOLD:
  - o_gen_en=0. o_valid=1, and o_data is stable until the transfer (o_valid & i_ready).
  - On transfer, o_valid drops on the next edge and words_left decrements.
  - If that word was the last one: o_done pulses and the state goes to IDLE. Otherwise the state goes to RUN.
- Throughput: one word per WORD_W+1 cycles when i_ready is held high.
- Sampling rule: the generator advances on the same edge that samples i_keystream, so the bit sampled is the pre-step output.
- i_abort:
  - In any non-IDLE state: next state is IDLE, o_valid=0, o_gen_en=0, no o_done, and the partial word is discarded.
  - If abort coincides with a transfer, the transfer stands (the consumer has seen it) but the run ends without o_done.
  - i_abort in IDLE has no effect.
- i_start while busy is ignored.
- words_left is LEN_W wide. i_len = 2^LEN_W-1 is legal and produces that many words with no wrap.

Test Plan:
- Reset and idle: hold i_rst=0, then release with no start -> all outputs 0, o_busy=0 indefinitely.
- Basic run with WARMUP=32, WORD_W=8: start with seedM=7'h5A, seedL=13'h1ABC, len=2 ->
  - o_gen_load high for 1 cycle, then o_gen_en high for 32 cycles.
  - 8 RUN cycles, then o_valid with o_data equal to bits 33..40 of the golden generator model, MSB-first; second word equals bits 41..48.
  - o_done pulses one cycle after the second transfer.
- Backpressure: hold i_ready=0 for 20 cycles in HOLD -> o_data and o_valid stable, o_gen_en=0, and the next word continues the bit sequence with no gap or skipped bits.
- Zero seeds: start with seedM=0, seedL=0 -> o_gen_seed_lfsrM=7'h01, o_gen_seed_lfsrL=13'h0001, and the keystream matches the model seeded with 1/1.
- Abort: assert i_abort on the 4th RUN cycle of word 1 -> IDLE next cycle, o_valid never asserted, no o_done. A following start then completes normally.
- Corner cases:
  - len=0 -> o_done pulses with no o_gen_load.
  - WARMUP=0 -> RUN immediately follows LOAD.
  - i_start during RUN is ignored.
  - Asynchronous i_rst asserted mid-HOLD -> o_valid=0 immediately, without waiting for a clock edge.
